// File: rtl/pagerank_responder_if.sv
// Bus bundle between a pagerank_responder and its engine/NoC router.
// The slave modport is the responder's view; master is the traffic source's view.
interface pagerank_responder_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH+4:0] my_data;
  logic [8:0]       request_in;
  logic             req_ready;
  logic [WIDTH+4:0] response;
  logic [1:0]       resp_dest;
  logic             resp_ready;
  logic [7:0]       drop_count;

  modport master (
    output my_data, request_in, resp_ready,
    input  req_ready, response, resp_dest, drop_count
  );

  modport slave (
    input  my_data, request_in, resp_ready,
    output req_ready, response, resp_dest, drop_count
  );
endinterface

// File: rtl/pagerank_responder.sv
// Serves remote node-value requests from a local copy of the cluster's 16-entry value table.
// Requests queue in a small FIFO; one registered response slot drains towards the router.
module pagerank_responder #(
  parameter logic [1:0]       ID        = 2'd0,
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = 16'h4000
) (
  input logic                  clk,
  input logic                  reset,
  pagerank_responder_if.slave  io_bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] DepthC = (PW+1)'(DEPTH);

  typedef enum logic {StEmpty, StHold} state_e;

  logic [WIDTH-1:0] r_table [16];
  logic [5:0]       r_fifo [DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [PW:0]      r_count;
  logic [7:0]       r_drop;
  state_e           r_state;
  logic [WIDTH+4:0] r_response;
  logic [1:0]       r_resp_dest;

  logic             w_wr_en;
  logic [3:0]       w_wr_off;
  logic [WIDTH-1:0] w_wr_val;
  logic             w_push, w_pop, w_drop, w_full, w_empty;
  logic [5:0]       w_head;
  logic [WIDTH-1:0] w_rdval;

  assign w_wr_en  = io_bus.my_data[0];
  assign w_wr_off = io_bus.my_data[4:1];
  assign w_wr_val = io_bus.my_data[WIDTH+4:5];

  // Full is judged on registered occupancy only, so a same-edge pop never frees a slot.
  assign w_full  = (r_count == DepthC);
  assign w_empty = (r_count == '0);
  assign w_push  = io_bus.request_in[0] && (io_bus.request_in[2:1] == ID) && !w_full;
  assign w_drop  = io_bus.request_in[0] && !w_push;
  assign w_pop   = !w_empty && ((r_state == StEmpty) || io_bus.resp_ready);

  assign w_head  = r_fifo[r_rptr];
  assign w_rdval = (w_wr_en && (w_wr_off == w_head[3:0])) ? w_wr_val : r_table[w_head[3:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) r_table[i] <= RESET_VAL;
    end else if (w_wr_en) begin
      r_table[w_wr_off] <= w_wr_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_fifo[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_drop  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= {io_bus.request_in[4:3], io_bus.request_in[8:5]};
        r_wptr         <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StEmpty;
      r_response  <= '0;
      r_resp_dest <= '0;
    end else begin
      case (r_state)
        StEmpty: begin
          if (w_pop) begin
            r_response  <= {w_rdval, w_head[3:0], 1'b1};
            r_resp_dest <= w_head[5:4];
            r_state     <= StHold;
          end
        end
        StHold: begin
          if (w_pop) begin
            r_response  <= {w_rdval, w_head[3:0], 1'b1};
            r_resp_dest <= w_head[5:4];
          end else if (io_bus.resp_ready) begin
            // Drained with nothing queued; resp_dest keeps the last route.
            r_response <= '0;
            r_state    <= StEmpty;
          end
        end
        default: r_state <= StEmpty;
      endcase
    end
  end

  assign io_bus.req_ready  = (r_count < DepthC);
  assign io_bus.response   = r_response;
  assign io_bus.resp_dest  = r_resp_dest;
  assign io_bus.drop_count = r_drop;
endmodule

// File: tb/tb_pagerank_responder.sv
// Directed bench for pagerank_responder (ID=1, DEPTH=4) with a queue-based reference model
// checked every cycle, plus literal expectations for each scenario.
module tb_pagerank_responder;
  localparam logic [1:0]  Id    = 2'd1;
  localparam int unsigned Depth = 4;

  logic clk;
  logic reset;
  logic chk_en;
  int   n_checks;
  int   n_err;

  pagerank_responder_if #(.WIDTH(16)) bus ();

  pagerank_responder #(
    .ID       (Id),
    .WIDTH    (16),
    .DEPTH    (Depth),
    .RESET_VAL(16'h4000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: request queue, value table, and the single response slot.
  int          q_off[$];
  int          q_src[$];
  logic [15:0] m_table[16];
  logic [20:0] m_resp = '0;
  logic [1:0]  m_dest = '0;
  int          m_drop = 0;

  always @(posedge clk or posedge reset) begin : model
    int          n_before;
    logic [15:0] v;
    if (reset) begin
      q_off.delete();
      q_src.delete();
      for (int i = 0; i < 16; i++) m_table[i] = 16'h4000;
      m_resp = '0;
      m_dest = '0;
      m_drop = 0;
    end else begin
      n_before = q_off.size();
      if (n_before > 0 && (!m_resp[0] || bus.resp_ready)) begin
        if (bus.my_data[0] && int'(bus.my_data[4:1]) == q_off[0]) v = bus.my_data[20:5];
        else v = m_table[q_off[0]];
        m_resp = {v, 4'(q_off[0]), 1'b1};
        m_dest = 2'(q_src[0]);
        void'(q_off.pop_front());
        void'(q_src.pop_front());
      end else if (m_resp[0] && bus.resp_ready) begin
        m_resp = '0;
      end
      if (bus.my_data[0]) m_table[bus.my_data[4:1]] = bus.my_data[20:5];
      if (bus.request_in[0]) begin
        if (bus.request_in[2:1] == Id && n_before < Depth) begin
          q_off.push_back(int'(bus.request_in[8:5]));
          q_src.push_back(int'(bus.request_in[4:3]));
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp response", 32'(bus.response), 32'(m_resp));
      check("cmp resp_dest", 32'(bus.resp_dest), 32'(m_dest));
      check("cmp req_ready", 32'(bus.req_ready), 32'(q_off.size() < Depth));
      check("cmp drop_count", 32'(bus.drop_count), 32'(m_drop));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] mkreq(input logic [3:0] off, input logic [1:0] src,
                                       input logic [1:0] dst);
    return {off, src, dst, 1'b1};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, " response"}, 32'(bus.response), 32'd0);
    check({tag, " resp_dest"}, 32'(bus.resp_dest), 32'd0);
    check({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, " drop_count"}, 32'(bus.drop_count), 32'd0);
  endtask

  initial begin
    logic [20:0] exp;
    n_checks = 0;
    n_err    = 0;
    chk_en   = 1'b0;
    reset    = 1'b0;
    bus.my_data    = '0;
    bus.request_in = '0;
    bus.resp_ready = 1'b1;

    #2 reset = 1'b1;
    #1 chk_en = 1'b1;
    check_reset_outputs("reset idle");
    #19 reset = 1'b0;
    step();

    // Read of an untouched entry after reset, one cycle after acceptance.
    bus.request_in = mkreq(4'd3, 2'd0, Id);
    step();
    bus.request_in = '0;
    check("accept edge valid", 32'(bus.response[0]), 32'd0);
    step();
    exp = {16'h4000, 4'd3, 1'b1};
    check("reset value read", 32'(bus.response), 32'(exp));
    check("reset value dest", 32'(bus.resp_dest), 32'd0);
    step();
    check("drain to empty", 32'(bus.response), 32'd0);

    // Write then read.
    bus.my_data = {16'h1234, 4'd7, 1'b1};
    step();
    bus.my_data    = '0;
    bus.request_in = mkreq(4'd7, 2'd2, Id);
    step();
    bus.request_in = '0;
    step();
    exp = {16'h1234, 4'd7, 1'b1};
    check("write then read", 32'(bus.response), 32'(exp));
    check("write then read dest", 32'(bus.resp_dest), 32'd2);

    // Forwarding of a same-edge table write into the pop.
    bus.request_in = mkreq(4'd5, 2'd0, Id);
    step();
    bus.request_in = '0;
    bus.my_data    = {16'hBEEF, 4'd5, 1'b1};
    step();
    bus.my_data = '0;
    exp = {16'hBEEF, 4'd5, 1'b1};
    check("forwarded value", 32'(bus.response), 32'(exp));
    step();
    check("forward drained", 32'(bus.response), 32'd0);

    // Backpressure: one held, four queued, sixth dropped.
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.request_in = mkreq(4'(i), 2'd3, Id);
      step();
      if (i == 3) check("ready with 3 queued", 32'(bus.req_ready), 32'd1);
      if (i == 4) check("ready when full", 32'(bus.req_ready), 32'd0);
    end
    bus.request_in = '0;
    exp = {16'h4000, 4'd0, 1'b1};
    check("held head", 32'(bus.response), 32'(exp));
    check("held dest", 32'(bus.resp_dest), 32'd3);
    check("full drop", 32'(bus.drop_count), 32'd1);
    step();
    check("held stable", 32'(bus.response), 32'(exp));
    bus.resp_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      step();
      exp = {16'h4000, 4'(i), 1'b1};
      check("drain order", 32'(bus.response), 32'(exp));
    end
    step();
    check("drain done", 32'(bus.response), 32'd0);
    check("dest kept", 32'(bus.resp_dest), 32'd3);

    // Misrouted requests and saturation.
    bus.request_in = mkreq(4'd0, 2'd0, 2'd2);
    step();
    bus.request_in = '0;
    check("misroute drop", 32'(bus.drop_count), 32'd2);
    check("misroute no resp", 32'(bus.response), 32'd0);
    for (int i = 0; i < 300; i++) begin
      bus.request_in = mkreq(4'd1, 2'd0, 2'd2);
      step();
    end
    bus.request_in = '0;
    check("drop saturate", 32'(bus.drop_count), 32'd255);

    // Reset mid-operation with a held response and three queued.
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.request_in = mkreq(4'(i), 2'd1, Id);
      step();
    end
    bus.request_in = '0;
    step();
    exp = {16'h4000, 4'd0, 1'b1};
    check("pre-reset hold", 32'(bus.response), 32'(exp));
    check("pre-reset dest", 32'(bus.resp_dest), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("mid reset");
    step();
    step();
    #2 reset = 1'b0;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("no stale response", 32'(bus.response), 32'd0);
    end
    bus.request_in = mkreq(4'd7, 2'd2, Id);
    step();
    bus.request_in = '0;
    step();
    exp = {16'h4000, 4'd7, 1'b1};
    check("table reset", 32'(bus.response), 32'(exp));
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
